sdc_sector_server: RTL and testbench
====================================

SDC_SECTOR_SERVER -- requirements
Module: sdc_sector_server

Interface
REQ-001 Parameter TIMEOUT, default 24'd1_000_000, is the maximum clk_sys cycles allowed per sector transfer, from request issue to the 512th byte.
REQ-002 Parameter DRIVES, default 4, is the number of request lines served; only the value 4 is supported.
REQ-003 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 sdc_rd  in  4  per-drive sector read request, level; held by the core until sdc_done.
REQ-006 sdc_sector  in  32  sector number; sampled when a request is granted.
REQ-007 sdc_busy  out  1  transfer in progress.
REQ-008 sdc_done  out  1  one-cycle pulse at the end of a transfer, successful or failed.
REQ-009 sdc_err  out  1  one-cycle pulse coincident with sdc_done on a failed transfer.
REQ-010 sdc_byte_in_strobe  out  1  one-cycle pulse per delivered byte.
REQ-011 sdc_byte_in_addr  out  9  byte offset within the sector, 0..511.
REQ-012 sdc_byte_in_data  out  8  byte value; valid while the strobe is high.
REQ-013 blk_req  out  1  block-device read request, held until blk_ack.
REQ-014 blk_lba  out  32  sector number latched for the device.
REQ-015 blk_drive  out  2  index of the granted drive.
REQ-016 blk_ack  in  1  device accepted the request.
REQ-017 blk_valid  in  1  device byte valid, one byte per cycle high.
REQ-018 blk_data  in  8  device byte.
REQ-019 blk_err  in  1  device read failure, pulse.

Function
REQ-020 FSM states SHALL be IDLE, GRANT, REQ, STREAM, DONE, RELEASE.
REQ-021 IDLE: if any eligible sdc_rd bit is set, go to GRANT; sdc_busy=0.
REQ-022 GRANT: pick the drive round-robin, starting one above the last served index and wrapping 3->0; latch sdc_sector into blk_lba and the index into blk_drive; assert sdc_busy in the same cycle; go to REQ.
REQ-023 REQ: assert blk_req until the cycle blk_ack=1, then go to STREAM and clear the byte counter to 0.
REQ-024 STREAM: each blk_valid cycle produces, one cycle later, sdc_byte_in_strobe=1, addr=counter, data=blk_data; the counter then increments.
REQ-025 After the strobe with addr=511, go to DONE; blk_valid beyond 512 bytes SHALL be ignored (no strobe, no counter wrap).
REQ-026 DONE: pulse sdc_done for one cycle; sdc_busy drops in the same cycle; go to RELEASE.
REQ-027 RELEASE: wait until the served sdc_rd bit is 0, then go to IDLE; a still-high bit SHALL NOT be re-granted.
REQ-028 A blk_err pulse in REQ or STREAM, or the timeout counter reaching TIMEOUT, SHALL go to DONE with sdc_err=1; no further strobes are issued and blk_req drops.
REQ-029 The timeout counter SHALL clear in GRANT, increment in REQ and STREAM, and saturate.
REQ-030 blk_valid and blk_err outside REQ/STREAM SHALL be ignored.
REQ-031 sdc_rd bits rising during a transfer SHALL stay pending and be served in round-robin order afterwards.
REQ-032 Changes on sdc_sector after GRANT SHALL NOT affect blk_lba.

Reset
REQ-033 Reset SHALL force IDLE and clear sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe, blk_req, the counters and the outputs (addr=0, data=0, blk_lba=0, blk_drive=0); the last-served pointer SHALL be set to 3.
REQ-034 Reset during STREAM SHALL abort with no sdc_done pulse and no further strobes.

Verification
REQ-035 Request sdc_rd=4'b0001, sector 0x00000123; device acks after 5 cycles and sends bytes 0..511 (value = addr[7:0]) -> 512 strobes with addr 0..511 and matching data, blk_lba=0x123, one sdc_done, sdc_err=0.
REQ-036 Request sdc_rd=4'b1010 asserted simultaneously -> drive 1 served first, then drive 3; blk_drive sequence 1,3.
REQ-037 blk_err pulse after 100 bytes -> sdc_done with sdc_err=1, exactly 100 strobes, sdc_busy=0.
REQ-038 Device never acks, TIMEOUT=64 -> sdc_done and sdc_err 64 cycles after GRANT (±1), blk_req dropped.
REQ-039 Reset asserted at byte 300 -> all outputs 0 immediately, no sdc_done; a later request completes normally.
REQ-040 sdc_rd bit held high after sdc_done -> no second grant until the bit drops; 600 blk_valid pulses -> exactly 512 strobes.

Source files
------------

// File: rtl/sdc_sector_server.sv
`default_nettype none
// ============================================================================
// Module   : sdc_sector_server
// Brief    : Round-robin arbiter that serves per-drive sector read requests
//            from a single block device, streaming 512 bytes per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module sdc_sector_server #(
  parameter logic [23:0] TIMEOUT = 24'd1_000_000,
  parameter int          DRIVES  = 4
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [DRIVES-1:0] sdc_rd,
  input  logic [31:0]       sdc_sector,
  output logic              sdc_busy,
  output logic              sdc_done,
  output logic              sdc_err,
  output logic              sdc_byte_in_strobe,
  output logic [8:0]        sdc_byte_in_addr,
  output logic [7:0]        sdc_byte_in_data,
  output logic              blk_req,
  output logic [31:0]       blk_lba,
  output logic [1:0]        blk_drive,
  input  logic              blk_ack,
  input  logic              blk_valid,
  input  logic [7:0]        blk_data,
  input  logic              blk_err
);

  localparam logic [8:0]  c_last_addr = 9'd511;
  localparam logic [23:0] c_tmo_max   = 24'hFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_REQ     = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_last;
  logic [1:0]  w_pick;
  logic        w_any;
  logic [9:0]  r_cnt;
  logic [23:0] r_tmo;
  logic        r_err;
  logic        w_tmo_hit;
  logic        w_fail;
  logic        w_take;
  logic        w_last_strobe;

  // Scan from the highest offset down so the drive just above r_last wins.
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      if (sdc_rd[r_last + 2'(k)]) begin
        w_pick = r_last + 2'(k);
        w_any  = 1'b1;
      end
    end
  end

  assign w_tmo_hit     = (r_tmo >= TIMEOUT - 24'd1);
  assign w_fail        = blk_err | w_tmo_hit;
  assign w_take        = (r_state == S_STREAM) && blk_valid && !r_cnt[9] && !w_fail;
  assign w_last_strobe = sdc_byte_in_strobe && (sdc_byte_in_addr == c_last_addr);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    sdc_busy = 1'b0;
    sdc_done = 1'b0;
    sdc_err  = 1'b0;
    blk_req  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_next = S_GRANT;
      end
      S_GRANT: begin
        sdc_busy = 1'b1;
        w_next   = w_any ? S_REQ : S_IDLE;
      end
      S_REQ: begin
        sdc_busy = 1'b1;
        blk_req  = 1'b1;
        if (w_fail)       w_next = S_DONE;
        else if (blk_ack) w_next = S_STREAM;
      end
      S_STREAM: begin
        sdc_busy = 1'b1;
        if (w_fail || w_last_strobe) w_next = S_DONE;
      end
      S_DONE: begin
        sdc_done = 1'b1;
        sdc_err  = r_err;
        w_next   = S_RELEASE;
      end
      S_RELEASE: begin
        if (!sdc_rd[blk_drive]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_last             <= 2'd3;
      r_cnt              <= '0;
      r_tmo              <= '0;
      r_err              <= 1'b0;
      blk_lba            <= '0;
      blk_drive          <= '0;
      sdc_byte_in_strobe <= 1'b0;
      sdc_byte_in_addr   <= '0;
      sdc_byte_in_data   <= '0;
    end else begin
      sdc_byte_in_strobe <= 1'b0;
      case (r_state)
        S_GRANT: begin
          if (w_any) begin
            blk_lba   <= sdc_sector;
            blk_drive <= w_pick;
            r_last    <= w_pick;
          end
          r_tmo <= '0;
          r_err <= 1'b0;
        end
        S_REQ: begin
          if (r_tmo != c_tmo_max) r_tmo <= r_tmo + 24'd1;
          if (w_fail)       r_err <= 1'b1;
          else if (blk_ack) r_cnt <= '0;
        end
        S_STREAM: begin
          if (r_tmo != c_tmo_max) r_tmo <= r_tmo + 24'd1;
          if (w_fail) r_err <= 1'b1;
          // Counter stops at 512 so surplus device bytes are dropped.
          if (w_take) begin
            sdc_byte_in_strobe <= 1'b1;
            sdc_byte_in_addr   <= r_cnt[8:0];
            sdc_byte_in_data   <= blk_data;
            r_cnt              <= r_cnt + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdc_sector_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdc_sector_server
// Brief    : Randomised scoreboard bench for sdc_sector_server.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdc_sector_server;

  typedef struct packed {
    logic        err;
    logic [1:0]  drive;
    logic [31:0] lba;
  } done_t;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  sdc_rd = '0;
  logic [31:0] sdc_sector = '0;
  logic        sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe;
  logic [8:0]  sdc_byte_in_addr;
  logic [7:0]  sdc_byte_in_data;
  logic        blk_req;
  logic [31:0] blk_lba;
  logic [1:0]  blk_drive;
  logic        blk_ack = 1'b0, blk_valid = 1'b0, blk_err = 1'b0;
  logic [7:0]  blk_data = '0;

  logic [3:0]  t_rd = '0;
  logic        t_busy, t_done, t_err, t_strobe, t_req;
  logic [8:0]  t_addr;
  logic [7:0]  t_data;
  logic [31:0] t_lba;
  logic [1:0]  t_drive;
  logic        t_zero = 1'b0;
  logic [7:0]  t_zero8 = '0;
  logic [31:0] t_sector = 32'h0000_0BAD;

  int n_checks = 0, n_errors = 0, n_done = 0, n_strobes = 0, cyc = 0, rr_last = 3;
  logic [16:0] q_byte[$];
  done_t       q_done[$];

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  sdc_sector_server #(.TIMEOUT(24'd4000), .DRIVES(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .sdc_rd(sdc_rd), .sdc_sector(sdc_sector),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done), .sdc_err(sdc_err),
    .sdc_byte_in_strobe(sdc_byte_in_strobe), .sdc_byte_in_addr(sdc_byte_in_addr),
    .sdc_byte_in_data(sdc_byte_in_data), .blk_req(blk_req), .blk_lba(blk_lba),
    .blk_drive(blk_drive), .blk_ack(blk_ack), .blk_valid(blk_valid),
    .blk_data(blk_data), .blk_err(blk_err)
  );

  sdc_sector_server #(.TIMEOUT(24'd64), .DRIVES(4)) dut_tmo (
    .clk_sys(clk_sys), .reset(reset), .sdc_rd(t_rd), .sdc_sector(t_sector),
    .sdc_busy(t_busy), .sdc_done(t_done), .sdc_err(t_err),
    .sdc_byte_in_strobe(t_strobe), .sdc_byte_in_addr(t_addr),
    .sdc_byte_in_data(t_data), .blk_req(t_req), .blk_lba(t_lba),
    .blk_drive(t_drive), .blk_ack(t_zero), .blk_valid(t_zero),
    .blk_data(t_zero8), .blk_err(t_zero)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input string msg);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference arbitration: first pending drive above the last one served.
  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int k = 1; k <= 4; k++)
      if (pend[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  always @(negedge clk_sys) begin : monitor
    logic [16:0] eb;
    done_t       ed;
    if (!reset) begin
      if (sdc_byte_in_strobe) begin
        n_strobes++;
        if (q_byte.size() == 0)
          fail_msg("strobe_unexpected", $sformatf("got strobe addr=%0d data=0x%0h, expected none",
                   sdc_byte_in_addr, sdc_byte_in_data));
        else begin
          eb = q_byte.pop_front();
          check("strobe_addr_data", 64'({sdc_byte_in_addr, sdc_byte_in_data}), 64'(eb));
        end
      end
      if (sdc_done) begin
        n_done++;
        if (q_done.size() == 0)
          fail_msg("done_unexpected", "got sdc_done, expected none");
        else begin
          ed = q_done.pop_front();
          check("done_err", 64'(sdc_err), 64'(ed.err));
          check("done_drive", 64'(blk_drive), 64'(ed.drive));
          check("done_lba", 64'(blk_lba), 64'(ed.lba));
          check("busy_at_done", 64'(sdc_busy), 64'(0));
          check("req_at_done", 64'(blk_req), 64'(0));
          check("bytes_left_at_done", 64'(q_byte.size()), 64'(0));
        end
      end else if (sdc_err) begin
        fail_msg("err_without_done", "got sdc_err=1 with sdc_done=0");
      end
    end
  end

  task automatic device(input int ack_dly, input int nvalid, input int err_after, input int gap_max,
                        input bit ramp, input logic [3:0] add_mask, input int rst_after);
    int t = 0;
    while (blk_req !== 1'b1 && t < 500) begin @(negedge clk_sys); t++; end
    if (blk_req !== 1'b1) begin
      fail_msg("blk_req_wait", "got no blk_req within 500 cycles, expected request");
      return;
    end
    sdc_rd = sdc_rd | add_mask;
    repeat (ack_dly) @(negedge clk_sys);
    blk_ack = 1'b1;
    @(negedge clk_sys);
    blk_ack = 1'b0;
    for (int k = 0; k < nvalid; k++) begin
      if (k == err_after) begin
        blk_err = 1'b1;
        @(negedge clk_sys);
        blk_err = 1'b0;
        return;
      end
      if (k == rst_after) begin
        #2 reset = 1'b1;
        return;
      end
      blk_valid = 1'b1;
      blk_data  = ramp ? k[7:0] : 8'($urandom);
      if (k < 512) q_byte.push_back({k[8:0], blk_data});
      if (k == 5) sdc_sector = $urandom;
      @(negedge clk_sys);
      blk_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk_sys);
    end
  endtask

  task automatic wait_done(input int base);
    int t = 0;
    while (n_done == base && t < 3000) begin @(negedge clk_sys); t++; end
    if (n_done == base) fail_msg("done_wait", "got no sdc_done within 3000 cycles, expected one");
  endtask

  task automatic xfer(input logic [31:0] lba, input int ack_dly, input int nvalid, input int err_after,
                      input int gap_max, input bit ramp, input logic [3:0] add_mask, input bit hold);
    done_t d;
    int drv, base, sb, exp_n, bad;
    drv = rr_pick(sdc_rd, rr_last);
    if (drv < 0) begin
      fail_msg("xfer_setup", "got no pending request, expected one");
      return;
    end
    sdc_sector = lba;
    d.err   = (err_after >= 0);
    d.drive = 2'(drv);
    d.lba   = lba;
    q_done.push_back(d);
    rr_last = drv;
    base = n_done;
    sb   = n_strobes;
    device(ack_dly, nvalid, err_after, gap_max, ramp, add_mask, -1);
    wait_done(base);
    @(negedge clk_sys);
    exp_n = (err_after >= 0) ? err_after : ((nvalid < 512) ? nvalid : 512);
    check("strobe_count", 64'(n_strobes - sb), 64'(exp_n));
    if (hold) begin
      bad = 0;
      repeat (30) begin
        @(negedge clk_sys);
        if (sdc_busy || blk_req) bad++;
      end
      check("no_regrant_while_held", 64'(bad), 64'(0));
    end
    sdc_rd[drv] = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got no completion by 3 ms, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    done_t d;
    int drv, base, sb, t, cg, lat;
    bit added;

    repeat (3) @(negedge clk_sys);
    check("reset_outputs", 64'({sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe, blk_req,
                                sdc_byte_in_addr, sdc_byte_in_data, blk_drive}), 64'(0));
    check("reset_lba", 64'(blk_lba), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // Single full sector with a ramp pattern
    sdc_rd = 4'b0001;
    xfer(32'h0000_0123, 5, 512, -1, 0, 1'b1, 4'b0000, 1'b0);

    // Two drives requested together are served 1 then 3
    @(negedge clk_sys);
    sdc_rd = 4'b1010;
    xfer(32'hA000_0001, 2, 512, -1, 2, 1'b0, 4'b0000, 1'b0);
    xfer(32'hB000_0003, 1, 512, -1, 2, 1'b0, 4'b0000, 1'b0);

    // Device error after 100 bytes
    @(negedge clk_sys);
    sdc_rd = 4'b0001 << $urandom_range(0, 3);
    xfer($urandom, 3, 512, 100, 1, 1'b0, 4'b0000, 1'b0);

    // Surplus bytes dropped and held request not re-granted
    @(negedge clk_sys);
    sdc_rd = 4'b0100;
    xfer($urandom, 0, 600, -1, 0, 1'b0, 4'b0000, 1'b1);

    // Reset in the middle of a stream
    @(negedge clk_sys);
    sdc_rd = 4'b0100;
    drv = rr_pick(sdc_rd, rr_last);
    sdc_sector = 32'h0000_0777;
    d.err = 1'b0; d.drive = 2'(drv); d.lba = sdc_sector;
    q_done.push_back(d);
    base = n_done;
    sb   = n_strobes;
    device(3, 512, -1, 0, 1'b1, 4'b0000, 300);
    #1;
    check("reset_abort_outputs", 64'({sdc_busy, sdc_done, sdc_err, sdc_byte_in_strobe, blk_req,
                                      sdc_byte_in_addr, sdc_byte_in_data, blk_drive}), 64'(0));
    check("reset_abort_lba", 64'(blk_lba), 64'(0));
    q_byte.delete();
    q_done.delete();
    sdc_rd = 4'b0000;
    repeat (3) @(negedge clk_sys);
    check("reset_abort_no_done", 64'(n_done), 64'(base));
    check("reset_abort_strobes", 64'(n_strobes - sb), 64'(300));
    reset = 1'b0;
    rr_last = 3;
    @(negedge clk_sys);
    sdc_rd = 4'b0100;
    xfer(32'h0000_0888, 2, 512, -1, 1, 1'b0, 4'b0000, 1'b0);

    // Random masks, late-rising requests and occasional device errors
    for (int it = 0; it < 4; it++) begin
      @(negedge clk_sys);
      sdc_rd = 4'($urandom_range(1, 15));
      added = 1'b0;
      while (sdc_rd != 4'b0000) begin
        int ea;
        ea = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 400)) : -1;
        xfer($urandom, $urandom_range(0, 6), 512, ea, 1, 1'b0,
             added ? 4'b0000 : (4'($urandom) & ~sdc_rd), 1'b0);
        added = 1'b1;
      end
    end

    // Timeout with a device that never acknowledges
    @(negedge clk_sys);
    t_rd = 4'b0001;
    t = 0;
    while (!t_busy && t < 20) begin @(negedge clk_sys); t++; end
    if (!t_busy) fail_msg("timeout_grant", "got no busy within 20 cycles, expected grant");
    else begin
      cg = cyc;
      t = 0;
      while (!t_done && t < 200) begin @(negedge clk_sys); t++; end
      if (!t_done) fail_msg("timeout_done", "got no sdc_done within 200 cycles, expected timeout");
      else begin
        lat = cyc - cg;
        n_checks++;
        if (lat < 63 || lat > 65) begin
          n_errors++;
          $display("FAIL timeout_latency: got %0d cycles, expected 63..65", lat);
        end
        check("timeout_err", 64'(t_err), 64'(1));
        check("timeout_req_dropped", 64'(t_req), 64'(0));
        check("timeout_busy", 64'(t_busy), 64'(0));
      end
    end
    t_rd = 4'b0000;
    repeat (5) @(negedge clk_sys);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
